// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundles the fetch stage's decoder/datapath-facing signals.
//   master : decoder/datapath side, drives control inputs and observes pc/status.
//   slave  : pc_fetch_unit side.
//   Inputs to the fetch unit: stall, instr, branch, not_branch, jump, jr, zero,
//   imm16, target26, rs_data.
//   Outputs from the fetch unit: pc, pc_plus4, fetch_valid, halted, addr_error,
//   instr_count.
interface pc_fetch_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic [31:0]      instr;
    logic             branch;
    logic             not_branch;
    logic             jump;
    logic             jr;
    logic             zero;
    logic [15:0]      imm16;
    logic [25:0]      target26;
    logic [31:0]      rs_data;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             fetch_valid;
    logic             halted;
    logic             addr_error;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output stall, instr, branch, not_branch, jump, jr, zero, imm16, target26, rs_data,
        input  pc, pc_plus4, fetch_valid, halted, addr_error, instr_count
    );

    modport slave (
        input  stall, instr, branch, not_branch, jump, jr, zero, imm16, target26, rs_data,
        output pc, pc_plus4, fetch_valid, halted, addr_error, instr_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencing for the single-cycle MIPS
// datapath. Holds the PC, forms the next PC from branch/jump/jr decode, runs a
// START/RUN/HALT sequencer, counts retired instructions and latches a sticky
// misaligned-jr error.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : pc_fetch_if.slave (control inputs in, pc/status out)
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   START   | first cycle after reset, pc not yet a real fetch
//   RUN     | fetching; pc/instr describe a real instruction
//   HALT    | halt word or misaligned jr seen; frozen until reset
//   (2'b11) | unreachable, behaves as HALT
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 32
) (
    input logic        clk,
    input logic        rst,
    pc_fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [31:0]      pc_plus4;
    logic [31:0]      br_off;
    logic             taken;
    logic [31:0]      next_pc;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_off   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        taken    = (bus.branch & bus.zero) | (bus.not_branch & ~bus.zero);
        next_pc  = pc_plus4;
        if (bus.jr)
            next_pc = bus.rs_data;
        else if (bus.jump)
            next_pc = {pc_plus4[31:28], bus.target26, 2'b00};
        else if (taken)
            next_pc = pc_plus4 + br_off;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                // stall outranks everything, then the halt word, then a bad jr
                if (!bus.stall) begin
                    if (bus.instr == HALT_WORD) begin
                        state_d = ST_HALT;
                    end else if (bus.jr && (bus.rs_data[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = next_pc;
                        if (cnt_q != {CNT_W{1'b1}})
                            cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_START;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = (state_q == ST_RUN);
    // bit 1 covers both HALT and the unreachable encoding
    assign bus.halted      = state_q[1];
    assign bus.addr_error  = err_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI = 32'h2008_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_if #(.CNT_W(32)) bus ();
    pc_fetch_if #(.CNT_W(32)) bus2 ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_WORD(HALT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .HALT_WORD(HALT), .CNT_W(32)) dut_wrap (
        .clk(clk), .rst(rst2), .bus(bus2)
    );

    typedef struct {
        logic        st;
        logic [31:0] ins;
        logic        br, nb, jp, jrr, zr;
        logic [15:0] imm;
        logic [25:0] tg;
        logic [31:0] rs;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        fv, hl, er;
    } exp_t;

    exp_t  sb[$];
    stim_t rows[$];
    int checks = 0;
    int errors = 0;

    function automatic stim_t mk(logic st, logic [31:0] ins, logic br, logic nb, logic jp,
                                 logic jrr, logic zr, logic [15:0] imm, logic [25:0] tg,
                                 logic [31:0] rs);
        stim_t s;
        s.st = st; s.ins = ins; s.br = br; s.nb = nb; s.jp = jp;
        s.jrr = jrr; s.zr = zr; s.imm = imm; s.tg = tg; s.rs = rs;
        return s;
    endfunction

    function automatic exp_t ex(string name, logic [31:0] pc, logic [31:0] cnt,
                                logic fv, logic hl, logic er);
        exp_t e;
        e.name = name; e.pc = pc; e.cnt = cnt; e.fv = fv; e.hl = hl; e.er = er;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        bus.stall = s.st; bus.instr = s.ins; bus.branch = s.br; bus.not_branch = s.nb;
        bus.jump = s.jp; bus.jr = s.jrr; bus.zero = s.zr; bus.imm16 = s.imm;
        bus.target26 = s.tg; bus.rs_data = s.rs;
    endtask

    task automatic push(input stim_t s, input exp_t e);
        rows.push_back(s);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        apply(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0));
        rst = 1'b1;
        #1;
        sb.push_back(ex("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        checks++;
        if ({bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error} !==
            {e.pc, e.cnt, e.fv, e.hl, e.er}) begin
            errors++;
            $display("FAIL %s: got pc=%h cnt=%0d fv=%b hl=%b er=%b, want pc=%h cnt=%0d fv=%b hl=%b er=%b",
                     e.name, bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error,
                     e.pc, e.cnt, e.fv, e.hl, e.er);
        end
        checks++;
        if (bus.pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_pc_plus4: got %h want %h", bus.pc_plus4, 32'h4);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        exp_t e;
        push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0), ex("seq_start", 32'h0, 0, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0), ex("seq_1", 32'h4, 1, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0), ex("seq_2", 32'h8, 2, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0), ex("seq_3", 32'hC, 3, 1, 0, 0));
        while (rows.size() > 0) begin
            apply(rows.pop_front());
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error} !==
                {e.pc, e.cnt, e.fv, e.hl, e.er}) begin
                errors++;
                $display("FAIL %s: got pc=%h cnt=%0d fv=%b hl=%b er=%b, want pc=%h cnt=%0d fv=%b hl=%b er=%b",
                         e.name, bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error,
                         e.pc, e.cnt, e.fv, e.hl, e.er);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0,    26'h0, 32'h0), ex("br_step",     32'h10, 4,  1, 0, 0));
        push(mk(0, ADDI, 1, 0, 0, 0, 1, 16'hFFFE, 26'h0, 32'h0), ex("beq_taken",   32'h0C, 5,  1, 0, 0));
        push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0,    26'h0, 32'h0), ex("br_step2",    32'h10, 6,  1, 0, 0));
        push(mk(0, ADDI, 1, 0, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0), ex("beq_nottkn",  32'h14, 7,  1, 0, 0));
        push(mk(0, ADDI, 0, 1, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0), ex("bne_taken1",  32'h10, 8,  1, 0, 0));
        push(mk(0, ADDI, 0, 1, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0), ex("bne_taken2",  32'h0C, 9,  1, 0, 0));
        push(mk(0, ADDI, 0, 1, 0, 0, 1, 16'hFFFE, 26'h0, 32'h0), ex("bne_nottkn",  32'h10, 10, 1, 0, 0));
        push(mk(0, ADDI, 1, 1, 0, 0, 0, 16'h0004, 26'h0, 32'h0), ex("both_z0",     32'h24, 11, 1, 0, 0));
        push(mk(0, ADDI, 1, 1, 0, 0, 1, 16'hFFFF, 26'h0, 32'h0), ex("both_z1",     32'h24, 12, 1, 0, 0));
        while (rows.size() > 0) begin
            apply(rows.pop_front());
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error} !==
                {e.pc, e.cnt, e.fv, e.hl, e.er}) begin
                errors++;
                $display("FAIL %s: got pc=%h cnt=%0d fv=%b hl=%b er=%b, want pc=%h cnt=%0d fv=%b hl=%b er=%b",
                         e.name, bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error,
                         e.pc, e.cnt, e.fv, e.hl, e.er);
            end
        end
    endtask

    task automatic test_jump();
        exp_t e;
        push(mk(0, ADDI, 0, 0, 0, 1, 0, 16'h0, 26'h0,     32'h3000_0040), ex("jr_far",      32'h3000_0040, 13, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 1, 0, 0, 16'h0, 26'h100,   32'h0),         ex("jump",        32'h3000_0400, 14, 1, 0, 0));
        push(mk(0, ADDI, 1, 0, 1, 0, 1, 16'h4, 26'h20,    32'h0),         ex("jump_over_br",32'h3000_0080, 15, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 1, 1, 0, 16'h0, 26'h3,     32'h20),        ex("jr_over_jump",32'h20,        16, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 0, 1, 0, 16'h0, 26'h0,     32'h80),        ex("jr_0x80",     32'h80,        17, 1, 0, 0));
        while (rows.size() > 0) begin
            apply(rows.pop_front());
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error} !==
                {e.pc, e.cnt, e.fv, e.hl, e.er}) begin
                errors++;
                $display("FAIL %s: got pc=%h cnt=%0d fv=%b hl=%b er=%b, want pc=%h cnt=%0d fv=%b hl=%b er=%b",
                         e.name, bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error,
                         e.pc, e.cnt, e.fv, e.hl, e.er);
            end
        end
    endtask

    task automatic test_stall_and_addr_error();
        exp_t e;
        for (int i = 0; i < 3; i++)
            push(mk(1, HALT, 0, 0, 1, 0, 0, 16'h0, 26'h100, 32'h0), ex("stall_hold", 32'h80, 17, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0),  ex("stall_release", 32'h84, 18, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 0, 1, 0, 16'h0, 26'h0, 32'h20), ex("jr_to_0x20",    32'h20, 19, 1, 0, 0));
        push(mk(0, ADDI, 0, 0, 1, 1, 0, 16'h0, 26'h0, 32'h82), ex("jr_misaligned", 32'h20, 19, 0, 1, 1));
        push(mk(0, ADDI, 0, 0, 0, 1, 0, 16'h0, 26'h0, 32'h40), ex("err_frozen",    32'h20, 19, 0, 1, 1));
        while (rows.size() > 0) begin
            apply(rows.pop_front());
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error} !==
                {e.pc, e.cnt, e.fv, e.hl, e.er}) begin
                errors++;
                $display("FAIL %s: got pc=%h cnt=%0d fv=%b hl=%b er=%b, want pc=%h cnt=%0d fv=%b hl=%b er=%b",
                         e.name, bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error,
                         e.pc, e.cnt, e.fv, e.hl, e.er);
            end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        // misaligned-jr halt from the previous scenario must clear only on reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0), ex("h_start", 32'h0, 0, 1, 0, 0));
        for (int i = 1; i <= 6; i++)
            push(mk(0, ADDI, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0),
                 ex("h_step", 32'(4 * i), 32'(i), 1, 0, 0));
        push(mk(0, HALT, 1, 0, 1, 1, 1, 16'h4, 26'h10, 32'h40), ex("halt_word", 32'h18, 6, 0, 1, 0));
        for (int i = 0; i < 5; i++)
            push(mk(i[0], ADDI, 0, 1, 1, 1, 0, 16'h4, 26'h10, 32'h42),
                 ex("halt_frozen", 32'h18, 6, 0, 1, 0));
        while (rows.size() > 0) begin
            apply(rows.pop_front());
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error} !==
                {e.pc, e.cnt, e.fv, e.hl, e.er}) begin
                errors++;
                $display("FAIL %s: got pc=%h cnt=%0d fv=%b hl=%b er=%b, want pc=%h cnt=%0d fv=%b hl=%b er=%b",
                         e.name, bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error,
                         e.pc, e.cnt, e.fv, e.hl, e.er);
            end
        end
        // asynchronous reset between edges
        #2;
        sb.push_back(ex("async_reset", 32'h0, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        e = sb.pop_front();
        checks++;
        if ({bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error} !==
            {e.pc, e.cnt, e.fv, e.hl, e.er}) begin
            errors++;
            $display("FAIL %s: got pc=%h cnt=%0d fv=%b hl=%b er=%b, want pc=%h cnt=%0d fv=%b hl=%b er=%b",
                     e.name, bus.pc, bus.instr_count, bus.fetch_valid, bus.halted, bus.addr_error,
                     e.pc, e.cnt, e.fv, e.hl, e.er);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [31:0] exp_p4[$];
        bus2.stall = 0; bus2.instr = ADDI; bus2.branch = 0; bus2.not_branch = 0;
        bus2.jump = 0; bus2.jr = 0; bus2.zero = 0; bus2.imm16 = 16'h0;
        bus2.target26 = 26'h0; bus2.rs_data = 32'h0;
        @(negedge clk);
        rst2 = 1'b0;
        sb.push_back(ex("wrap_start", 32'hFFFF_FFF8, 0, 1, 0, 0)); exp_p4.push_back(32'hFFFF_FFFC);
        sb.push_back(ex("wrap_1",     32'hFFFF_FFFC, 1, 1, 0, 0)); exp_p4.push_back(32'h0000_0000);
        sb.push_back(ex("wrap_2",     32'h0000_0000, 2, 1, 0, 0)); exp_p4.push_back(32'h0000_0004);
        while (sb.size() > 0) begin
            logic [31:0] p4;
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            p4 = exp_p4.pop_front();
            checks++;
            if ({bus2.pc, bus2.instr_count, bus2.fetch_valid, bus2.halted, bus2.addr_error, bus2.pc_plus4} !==
                {e.pc, e.cnt, e.fv, e.hl, e.er, p4}) begin
                errors++;
                $display("FAIL %s: got pc=%h p4=%h cnt=%0d fv=%b hl=%b er=%b, want pc=%h p4=%h cnt=%0d fv=%b hl=%b er=%b",
                         e.name, bus2.pc, bus2.pc_plus4, bus2.instr_count, bus2.fetch_valid, bus2.halted,
                         bus2.addr_error, e.pc, p4, e.cnt, e.fv, e.hl, e.er);
            end
        end
    endtask

    initial begin
        bus2.stall = 0; bus2.instr = ADDI; bus2.branch = 0; bus2.not_branch = 0;
        bus2.jump = 0; bus2.jr = 0; bus2.zero = 0; bus2.imm16 = 16'h0;
        bus2.target26 = 26'h0; bus2.rs_data = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_and_addr_error();
        test_halt();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-sequencing stage that sits directly upstream of the main control decoder in the single-cycle MIPS datapath. It holds the PC, presents it to instruction memory, and forms the next PC from the decoder's Branch/NotBranch/Jump outputs, the ALU zero flag and jr decode. A 3-state FSM handles post-reset startup, run and halt. The block also keeps a retired-instruction counter and a sticky address-error flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hold PC and counter this cycle.
instr  in  32  instruction word read from imem at current pc.
branch  in  1  beq decode (MainControl Branch).
not_branch  in  1  bne decode (MainControl NotBranch).
jump  in  1  j/jal decode (MainControl Jump).
jr  in  1  jump-register decode (R-type funct 001000).
zero  in  1  ALU zero flag for current instruction.
imm16  in  16  instr[15:0] branch offset.
target26  in  26  instr[25:0] jump target.
rs_data  in  32  register rs value for jr.
pc  out  32  current fetch address.
pc_plus4  out  32  pc+4, used as jal link value.
fetch_valid  out  1  high only in RUN; pc/instr are a real instruction.
halted  out  1  high in HALT.
addr_error  out  1  sticky misaligned-jr flag.
instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, any time incl. mid-run): pc=RESET_PC, state=START, instr_count=0, addr_error=0, fetch_valid=0, halted=0.
- States: START(00), RUN(01), HALT(10); 11 unreachable -> treated as HALT.
- START: first rising edge with rst low -> RUN; pc unchanged; no count. fetch_valid=0.
- RUN, stall=1: pc, count, state hold. Stall overrides halt detection and all redirects.
- RUN, stall=0, instr==HALT_WORD: -> HALT; pc holds (points at halt word); count not incremented. Halt check takes priority over any control inputs.
- RUN, stall=0, otherwise: pc <= next_pc; instr_count <= instr_count+1, saturating at all-ones.
- next_pc priority: jr > jump > branch taken > pc_plus4.
  - taken = (branch & zero) | (not_branch & ~zero).
  - branch target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, 32-bit modulo.
  - jump target = {pc_plus4[31:28], target26, 2'b00}.
  - jr target = rs_data. If rs_data[1:0]!=0: addr_error<=1, state->HALT, pc holds, no count.
- pc_plus4 = pc + 4, combinational, wraps modulo 2^32 (32'hFFFF_FFFC -> 0). Sequential wrap is legal; no error raised.
- branch and not_branch both high: taken regardless of zero. Decoder never drives both; this is defined only for determinism.
- HALT: all state frozen until rst; halted=1, fetch_valid=0. Inputs ignored.
- addr_error clears only on rst.
- Outputs are registered state or simple functions of registered state. There is no combinational path from control inputs to pc.

Test Plan:
- Reset, release, 4 non-stalled edges of addi words -> pc 0,0,4,8,12; fetch_valid 0 then 1; instr_count=3.
- At pc=0x10, beq=1 zero=1 imm16=0xFFFE -> pc=0x0C. Same with zero=0 -> pc=0x14. bne with zero=0 -> pc=0x0C.
- At pc=0x3000_0040, jump=1 target26=0x0000100 -> pc=0x3000_0400. At pc=0x20, jr=1 rs_data=0x80 -> 0x80. jr with rs_data=0x82 -> addr_error=1, halted=1, pc stays 0x20.
- stall=1 for 3 cycles with jump=1 and instr=HALT_WORD -> pc and count unchanged, state RUN; release stall with normal instr -> advances.
- instr=HALT_WORD at pc=0x18 -> halted=1, pc=0x18 held across 5 edges, count frozen. Assert rst mid-cycle -> pc=RESET_PC immediately, without waiting for a clock edge.
- RESET_PC=0xFFFF_FFF8: two sequential steps -> 0xFFFF_FFFC, 0x0000_0000, no error.
